// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: sequences one ALU operation through a register file.
// One operation takes IDLE -> READ -> WRITE -> DONE, one cycle per state.
// Optional feature: define SEQ_CLEAR_EN to add a CLEAR state that zeroes
// registers 1..31 with one write per cycle when clr_all is seen in IDLE.
module rf_op_sequencer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  input  logic [4:0]  dst,
  input  logic        clr_all,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        ovf
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
`ifdef SEQ_CLEAR_EN
  localparam logic [2:0] CLEAR = 3'd4;
`else
  // clr_all has no function in this build
  logic unused_clr_all;
  assign unused_clr_all = clr_all;
`endif

  logic [2:0]  state;
  logic [2:0]  op_q;
  logic [4:0]  dst_q;
  logic [31:0] calc;
  logic        calc_ovf;
  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = rf_rdata1 + rf_rdata2;
  assign diff = rf_rdata1 - rf_rdata2;

  // ALU on the register file read data; overflow judged from operand/result signs
  always_comb begin
    calc     = 32'd0;
    calc_ovf = 1'b0;
    case (op_q)
      3'd0: begin
        calc     = sum;
        calc_ovf = (rf_rdata1[31] == rf_rdata2[31]) && (sum[31] != rf_rdata1[31]);
      end
      3'd1: begin
        calc     = diff;
        calc_ovf = (rf_rdata1[31] != rf_rdata2[31]) && (diff[31] != rf_rdata1[31]);
      end
      3'd2: calc = rf_rdata1 & rf_rdata2;
      3'd3: calc = rf_rdata1 | rf_rdata2;
      3'd4: calc = rf_rdata1 ^ rf_rdata2;
      3'd5: calc = {31'd0, $signed(rf_rdata1) < $signed(rf_rdata2)};
      3'd6: calc = rf_rdata1 << rf_rdata2[4:0];
      default: calc = rf_rdata1 >> rf_rdata2[4:0];
    endcase
  end

  // Sequencer FSM; every output is registered here
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      op_q      <= 3'd0;
      dst_q     <= 5'd0;
      rf_raddr1 <= 5'd0;
      rf_raddr2 <= 5'd0;
      rf_wen    <= 1'b0;
      rf_waddr  <= 5'd0;
      rf_wdata  <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 32'd0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          rf_wen <= 1'b0;
`ifdef SEQ_CLEAR_EN
          // clear has priority over a simultaneous start
          if (clr_all) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            rf_wen   <= 1'b1;
            rf_waddr <= 5'd1;
            rf_wdata <= 32'd0;
          end else
`endif
          if (start) begin
            state     <= READ;
            busy      <= 1'b1;
            op_q      <= op;
            dst_q     <= dst;
            rf_raddr1 <= src1;
            rf_raddr2 <= src2;
          end
        end
        READ: begin
          result   <= calc;
          ovf      <= calc_ovf;
          rf_waddr <= dst_q;
          rf_wdata <= calc;
          rf_wen   <= (dst_q != 5'd0);
          state    <= WRITE;
        end
        WRITE: begin
          rf_wen <= 1'b0;
          state  <= DONE;
        end
`ifdef SEQ_CLEAR_EN
        CLEAR: begin
          if (rf_waddr == 5'd31) begin
            rf_wen <= 1'b0;
            state  <= DONE;
          end else begin
            rf_waddr <= rf_waddr + 5'd1;
          end
        end
`endif
        DONE: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          rf_wen <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          rf_wen <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// tb_rf_op_sequencer: directed plus randomized checks of rf_op_sequencer
// against a register file model and an arithmetic reference model.
module tb_rf_op_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [2:0]  op;
  logic [4:0]  src1, src2, dst;
  logic        clr_all;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy, done;
  logic [31:0] result;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  int done_cnt = 0;

  logic [31:0] regs [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = 5'd0;
  logic [31:0] pl_data = 32'd0;

  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;

  always #5 clk = ~clk;

  rf_op_sequencer dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op),
    .src1(src1), .src2(src2), .dst(dst), .clr_all(clr_all),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  // Register file model with a preload port for the stimulus
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];
  always @(posedge clk) begin
    if (!resetn && !pl_en) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (pl_en) regs[pl_addr] <= pl_data;
    else if (rf_wen) regs[rf_waddr] <= rf_wdata;
  end

  // Pulse counters
  always @(posedge clk) begin
    if (rf_wen) wen_cnt <= wen_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic v);
    longint sa, sb, s;
    logic [4:0] sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    v = 1'b0;
    r = 32'd0;
    case (o)
      3'd0: begin s = sa + sb; r = a + b; v = (s > MAXP) || (s < MINN); end
      3'd1: begin s = sa - sb; r = a - b; v = (s > MAXP) || (s < MINN); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: r = a << sh;
      default: r = a >> sh;
    endcase
  endfunction

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One full operation with cycle-exact checks; glitch pulses start in READ and WRITE
  task automatic run_op(input logic [2:0] o, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input bit glitch, input string tag);
    logic [31:0] er;
    logic ev;
    int w0, d0;
    ref_op(o, regs[s1], regs[s2], er, ev);
    @(negedge clk);
    w0 = wen_cnt; d0 = done_cnt;
    start = 1'b1; op = o; src1 = s1; src2 = s2; dst = d;
    @(negedge clk);
    start = glitch;
    op = ~o; src1 = ~s1; dst = ~d;
    chk({tag, " busy_read"}, {31'd0, busy}, 32'd1);
    chk({tag, " raddr1"}, {27'd0, rf_raddr1}, {27'd0, s1});
    chk({tag, " raddr2"}, {27'd0, rf_raddr2}, {27'd0, s2});
    @(negedge clk);
    start = glitch;
    chk({tag, " wen_write"}, {31'd0, rf_wen}, {31'd0, d != 5'd0});
    if (d != 5'd0) begin
      chk({tag, " waddr"}, {27'd0, rf_waddr}, {27'd0, d});
      chk({tag, " wdata"}, rf_wdata, er);
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, " wen_done"}, {31'd0, rf_wen}, 32'd0);
    chk({tag, " done_early"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, " result"}, result, er);
    chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, ev});
    @(negedge clk);
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " wen_count"}, wen_cnt - w0, (d != 5'd0) ? 1 : 0);
    chk({tag, " done_count"}, done_cnt - d0, 1);
  endtask

  initial begin
    int w0, d0;
    logic [2:0] ro;
    logic [4:0] ra, rb, rd;
    resetn = 1'b0; start = 1'b0; op = 3'd0; src1 = 5'd0; src2 = 5'd0; dst = 5'd0; clr_all = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst wen", {31'd0, rf_wen}, 32'd0);
    chk("rst ovf", {31'd0, ovf}, 32'd0);
    chk("rst raddr", {22'd0, rf_raddr1, rf_raddr2}, 32'd0);
    chk("rst waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst wdata", rf_wdata, 32'd0);
    chk("rst result", result, 32'd0);
    resetn = 1'b1;

    // Directed: ADD 5+7
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    run_op(3'd0, 5'd1, 5'd2, 5'd3, 1'b0, "add");
    chk("add stored", regs[3], 32'd12);

    // Directed: SUB overflow, then SLT on the same operands
    preload(5'd1, 32'h8000_0000);
    preload(5'd2, 32'd1);
    run_op(3'd1, 5'd1, 5'd2, 5'd4, 1'b0, "sub_ovf");
    chk("sub const", result, 32'h7FFF_FFFF);
    chk("sub ovf const", {31'd0, ovf}, 32'd1);
    run_op(3'd5, 5'd1, 5'd2, 5'd4, 1'b0, "slt");
    chk("slt const", result, 32'd1);

    // Start pulsed while busy is ignored
    run_op(3'd4, 5'd3, 5'd4, 5'd5, 1'b1, "ignored_start");

    // dst=0 never writes
    run_op(3'd3, 5'd1, 5'd2, 5'd0, 1'b0, "or_dst0");

    // Randomized operations
    for (int n = 0; n < 24; n++) begin
      ra = 5'($urandom_range(1, 31));
      rb = 5'($urandom_range(1, 31));
      preload(ra, $urandom);
      preload(rb, (n % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      ro = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      run_op(ro, ra, rb, rd, n[0], "rand");
    end

    // Reset while in WRITE aborts the operation
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1; op = 3'd0; src1 = 5'd1; src2 = 5'd2; dst = 5'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort wen_write", {31'd0, rf_wen}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("abort wen", {31'd0, rf_wen}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort result", result, 32'd0);
    w0 = wen_cnt;
    repeat (5) @(negedge clk);
    chk("abort no_done", done_cnt - d0, 0);
    chk("abort no_wen", wen_cnt - w0, 0);

    // Register clear request
    preload(5'd9, 32'hDEAD_BEEF);
    @(negedge clk);
    w0 = wen_cnt; d0 = done_cnt;
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
`ifdef SEQ_CLEAR_EN
    for (int i = 1; i <= 31; i++) begin
      chk("clr wen", {31'd0, rf_wen}, 32'd1);
      chk("clr waddr", {27'd0, rf_waddr}, i);
      chk("clr wdata", rf_wdata, 32'd0);
      chk("clr busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    chk("clr wen_end", {31'd0, rf_wen}, 32'd0);
    @(negedge clk);
    chk("clr done", {31'd0, done}, 32'd1);
    chk("clr busy_end", {31'd0, busy}, 32'd0);
    chk("clr r9", regs[9], 32'd0);
`else
    repeat (40) @(negedge clk);
    chk("noclr wen", wen_cnt - w0, 0);
    chk("noclr done", done_cnt - d0, 0);
    chk("noclr busy", {31'd0, busy}, 32'd0);
    chk("noclr r9", regs[9], 32'hDEAD_BEEF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
